// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg : shared state encoding and output-mux select codes for UART Tx
// Revision : 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] SEL_STOP  = 2'b00;
  localparam logic [1:0] SEL_START = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if : host request / Tx datapath strobes of the frame sequencer
// Revision : 1.0
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if;

  logic       Data_Valid;
  logic       PAR_EN;
  logic       Tick;
  logic       Load;
  logic       Ser_EN;
  logic [1:0] Mux_Sel;
  logic       Busy;
  logic       Done;

  modport master (
    output Data_Valid, PAR_EN, Tick,
    input  Load, Ser_EN, Mux_Sel, Busy, Done
  );

  modport slave (
    input  Data_Valid, PAR_EN, Tick,
    output Load, Ser_EN, Mux_Sel, Busy, Done
  );

endinterface
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_ctrl : UART Tx frame sequencer (start, data, parity, stop slots)
// Revision : 1.0
// ---------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_W      = 4
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic             par_en_q, par_en_nxt;
  logic             done_q, done_nxt;
  logic             load;
  logic             ser_en;
  logic [1:0]       mux_sel;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      par_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      par_en_q <= par_en_nxt;
      done_q   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    par_en_nxt  = par_en_q;
    done_nxt    = 1'b0;
    load        = 1'b0;
    ser_en      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Data_Valid) begin
          state_nxt  = START;
          load       = 1'b1;
          par_en_nxt = bus.PAR_EN;
        end
      end
      START: begin
        if (bus.Tick) begin
          state_nxt   = DATA;
          bit_cnt_nxt = '0;
        end
      end
      DATA: begin
        // The LSB is already presented by Load, so the last data slot needs no shift.
        if (bus.Tick) begin
          if (bit_cnt == LAST_BIT) begin
            state_nxt = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            ser_en      = 1'b1;
          end
        end
      end
      PARITY: begin
        if (bus.Tick) state_nxt = STOP;
      end
      STOP: begin
        if (bus.Tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mux_sel = SEL_STOP;
    case (state)
      START:   mux_sel = SEL_START;
      DATA:    mux_sel = SEL_DATA;
      PARITY:  mux_sel = SEL_PAR;
      default: mux_sel = SEL_STOP;
    endcase
  end

  assign bus.Load    = load;
  assign bus.Ser_EN  = ser_en;
  assign bus.Mux_Sel = mux_sel;
  assign bus.Busy    = (state != IDLE);
  assign bus.Done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl : self-checking bench with a slot-counting frame model
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(.DATA_WIDTH(DW), .CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // Frame model: slot 0 = start, 1..DW = data, DW+1 = parity (if enabled), last = stop.
  bit m_active = 1'b0;
  int m_slot   = 0;
  bit m_par    = 1'b0;
  bit m_done   = 1'b0;
  int m_last;

  always_comb m_last = DW + 1 + int'(m_par);

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_active <= 1'b0;
      m_slot   <= 0;
      m_par    <= 1'b0;
      m_done   <= 1'b0;
    end else begin
      m_done <= m_active && bus.Tick && (m_slot == m_last);
      if (!m_active) begin
        if (bus.Data_Valid) begin
          m_active <= 1'b1;
          m_slot   <= 0;
          m_par    <= bus.PAR_EN;
        end
      end else if (bus.Tick) begin
        if (m_slot == m_last) m_active <= 1'b0;
        else                  m_slot   <= m_slot + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  int load_cnt = 0;
  int ser_cnt  = 0;
  int done_cnt = 0;
  logic [1:0] mux_q[$];

  always @(negedge CLK) begin
    if (chk_en) begin
      logic [1:0] e_mux;
      if (!m_active)                           e_mux = 2'b00;
      else if (m_slot == 0)                    e_mux = 2'b01;
      else if (m_slot <= DW)                   e_mux = 2'b10;
      else if (m_par && m_slot == DW + 1)      e_mux = 2'b11;
      else                                     e_mux = 2'b00;
      chk("mux_sel", 32'(bus.Mux_Sel), 32'(e_mux));
      chk("busy",    32'(bus.Busy),    32'(m_active));
      chk("load",    32'(bus.Load),    32'(!m_active && bus.Data_Valid));
      chk("ser_en",  32'(bus.Ser_EN),  32'(m_active && bus.Tick && m_slot >= 1 && m_slot <= DW - 1));
      chk("done",    32'(bus.Done),    32'(m_done));
      if (bus.Load)   load_cnt++;
      if (bus.Ser_EN) ser_cnt++;
      if (bus.Done)   done_cnt++;
      if (bus.Tick && bus.Busy) mux_q.push_back(bus.Mux_Sel);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) cyc();
      bus.Tick = 1'b1;
      cyc();
      bus.Tick = 1'b0;
    end
  endtask

  task automatic clear_counts();
    load_cnt = 0;
    ser_cnt  = 0;
    done_cnt = 0;
    mux_q.delete();
  endtask

  task automatic chk_seq(input string name, input logic [1:0] exp[$]);
    chk({name, "_len"}, 32'(mux_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < mux_q.size(); i++)
      chk(name, 32'(mux_q[i]), 32'(exp[i]));
  endtask

  logic [1:0] seq_nopar[$] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
  logic [1:0] seq_par[$]   = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00};

  initial begin
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.Tick       = 1'b0;
    repeat (3) cyc();
    RST = 1'b0;
    chk_en = 1'b1;
    chk("rst_mux",  32'(bus.Mux_Sel), 32'd0);
    chk("rst_busy", 32'(bus.Busy),    32'd0);

    // Reset while idle, checked before the next clock edge
    repeat (3) cyc();
    #2 RST = 1'b1;
    #1;
    chk("rst1_mux",  32'(bus.Mux_Sel), 32'd0);
    chk("rst1_busy", 32'(bus.Busy),    32'd0);
    chk("rst1_load", 32'(bus.Load),    32'd0);
    chk("rst1_ser",  32'(bus.Ser_EN),  32'd0);
    chk("rst1_done", 32'(bus.Done),    32'd0);
    cyc();
    RST = 1'b0;
    cyc();

    // Parity off, slow ticks
    clear_counts();
    bus.Data_Valid = 1'b1;
    chk("t2_load_pre_busy", 32'(bus.Busy), 32'd0);
    cyc();
    bus.Data_Valid = 1'b0;
    chk("t2_busy_after_load", 32'(bus.Busy), 32'd1);
    run_ticks(9, 16);
    chk("t2_no_early_done", 32'(done_cnt), 32'd0);
    run_ticks(1, 16);
    chk("t2_done_now", 32'(bus.Done), 32'd1);
    chk("t2_busy_low", 32'(bus.Busy), 32'd0);
    cyc();
    chk("t2_loads", 32'(load_cnt), 32'd1);
    chk("t2_shifts", 32'(ser_cnt), 32'd7);
    chk("t2_dones", 32'(done_cnt), 32'd1);
    chk_seq("t2_seq", seq_nopar);

    // Parity on at accept, PAR_EN dropped mid-frame
    clear_counts();
    bus.PAR_EN     = 1'b1;
    bus.Data_Valid = 1'b1;
    cyc();
    bus.Data_Valid = 1'b0;
    run_ticks(3, 16);
    bus.PAR_EN = 1'b0;
    run_ticks(8, 16);
    chk("t3_done_now", 32'(bus.Done), 32'd1);
    repeat (3) cyc();
    chk("t3_shifts", 32'(ser_cnt), 32'd7);
    chk("t3_dones", 32'(done_cnt), 32'd1);
    chk_seq("t3_seq", seq_par);

    // Back-to-back frames with Data_Valid held high
    clear_counts();
    bus.Data_Valid = 1'b1;
    cyc();
    run_ticks(10, 4);
    chk("t4_reload_in_done", 32'(bus.Load), 32'd1);
    chk("t4_done_cycle", 32'(bus.Done), 32'd1);
    cyc();
    run_ticks(10, 4);
    bus.Data_Valid = 1'b0;
    cyc();
    cyc();
    chk("t4_loads", 32'(load_cnt), 32'd2);
    chk("t4_dones", 32'(done_cnt), 32'd2);
    chk("t4_shifts", 32'(ser_cnt), 32'd14);

    // Reset mid-frame once bit_cnt has reached 4
    clear_counts();
    bus.Data_Valid = 1'b1;
    cyc();
    bus.Data_Valid = 1'b0;
    run_ticks(5, 4);
    chk("t5_mid_mux", 32'(bus.Mux_Sel), 32'd2);
    cyc();
    #2 RST = 1'b1;
    #1;
    chk("t5_rst_mux",  32'(bus.Mux_Sel), 32'd0);
    chk("t5_rst_busy", 32'(bus.Busy),    32'd0);
    cyc();
    RST = 1'b0;
    run_ticks(6, 4);
    chk("t5_no_done", 32'(done_cnt), 32'd0);

    // Back-to-back ticks for the restarted frame
    clear_counts();
    bus.Data_Valid = 1'b1;
    cyc();
    bus.Data_Valid = 1'b0;
    run_ticks(10, 1);
    cyc();
    chk("t6_shifts", 32'(ser_cnt), 32'd7);
    chk("t6_dones", 32'(done_cnt), 32'd1);
    chk_seq("t6_seq", seq_nopar);

    // Ticks in IDLE do nothing
    bus.Tick = 1'b1;
    repeat (4) cyc();
    bus.Tick = 1'b0;
    chk("t6_idle_busy", 32'(bus.Busy), 32'd0);
    chk("t6_idle_mux", 32'(bus.Mux_Sel), 32'd0);
    repeat (2) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire
